eth_preamble_sync: RTL and testbench
====================================

ETH_PREAMBLE_SYNC -- requirements
Module: eth_preamble_sync

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE_BITS, default 16, meaning the minimum count of alternating bits before the SFD that makes a frame valid.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1518, meaning the maximum post-SFD byte count before the frame is dropped.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_carrier  input  1  line activity; high while a frame is on the wire.
REQ-006 SHALL have port i_bit_valid  input  1  qualifies i_bit for one cycle.
REQ-007 SHALL have port i_bit  input  1  decoded line bit, LSB-first per byte.
REQ-008 SHALL have port o_byte  output  8  assembled frame byte.
REQ-009 SHALL have port o_byte_valid  output  1  one-cycle strobe qualifying o_byte.
REQ-010 SHALL have port o_sof  output  1  high with o_byte_valid on the first byte after the SFD only.
REQ-011 SHALL have port o_eof  output  1  one-cycle end-of-frame pulse.
REQ-012 SHALL have port o_err  output  1  one-cycle error pulse.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-014 SHALL consume i_bit only in cycles with i_bit_valid=1 and i_carrier=1; when i_carrier=0 and i_bit_valid=1 coincide, the carrier drop takes priority and the bit is discarded.
REQ-015 IDLE: valid bit 1 -> PREAMBLE with alt_count=1, prev_bit=1; valid bit 0 is ignored.
REQ-016 PREAMBLE: bit != prev_bit -> alt_count+1, saturating at MIN_PREAMBLE_BITS; prev_bit updated on every valid bit.
REQ-017 PREAMBLE: bit=1 with prev_bit=1 (SFD end, 0xD5 LSB-first) -> DATA if alt_count >= MIN_PREAMBLE_BITS, otherwise -> DROP with o_err pulse.
REQ-018 PREAMBLE: bit=0 with prev_bit=0 -> DROP with o_err pulse.
REQ-019 PREAMBLE: carrier low -> IDLE with no o_err and no o_eof.
REQ-020 DATA: valid bit is written to shift_reg[bit_idx] and bit_idx increments modulo 8; on bit_idx=7, o_byte/o_byte_valid are asserted in the next cycle (latency 1 cycle from the 8th bit).
REQ-021 DATA: o_sof SHALL be asserted only on byte_count=0; byte_count saturates, with width $clog2(MAX_FRAME_BYTES+1).
REQ-022 DATA: completion of a byte with byte_count = MAX_FRAME_BYTES -> that byte is suppressed, o_err and o_eof pulse, state -> DROP.
REQ-023 DATA: carrier low with bit_idx=0 -> o_eof pulse the next cycle, state -> IDLE; with bit_idx!=0 -> o_eof and o_err pulse together, partial byte discarded, state -> IDLE.
REQ-024 DROP: all bits are ignored; carrier low -> IDLE with no pulses.
REQ-025 bit_idx, byte_count, alt_count SHALL clear on every entry to IDLE and DATA.
REQ-026 o_byte SHALL hold its last value when o_byte_valid=0; o_sof, o_eof, o_err SHALL never be high for more than one cycle.

Reset
REQ-027 i_rst=1 SHALL force state IDLE and all counters to 0, and set o_byte=8'h00 and o_byte_valid=o_sof=o_eof=o_err=0 in the following cycle, including mid-frame.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 The state enum and the constants PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5 SHALL live in shared package eth_pkg.
REQ-030 SHALL be a single module with no sub-modules; its output feeds the MAC header parser stage.

Verification
REQ-031 7x 0x55 + 0xD5 + bytes 0x01,0x02,0x03, then carrier low -> three o_byte_valid strobes 0x01,0x02,0x03, o_sof on 0x01, a single o_eof, no o_err.
REQ-032 1x 0x55 + 0xD5 (alt_count 15 < 16) -> o_err pulse, no o_byte_valid, return to IDLE after carrier low.
REQ-033 Preamble 0x55 0x51 (two consecutive 0s) -> o_err pulse, DROP until carrier low, no bytes.
REQ-034 Valid preamble/SFD + 0xAA + 3 bits then carrier low -> one byte 0xAA, o_eof and o_err in the same cycle.
REQ-035 MAX_FRAME_BYTES=4, send 5 bytes -> 4 strobes, the 5th suppressed, o_err+o_eof, later bits ignored.
REQ-036 i_rst asserted after the 2nd data byte -> all outputs 0 next cycle; a new full frame afterwards is received correctly with o_sof.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: synchroniser states and
// the line-coding constants that frame every packet.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } sync_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_preamble_sync.sv
// Bit-serial Ethernet receive front end: locks onto the alternating preamble and
// SFD, then assembles LSB-first frame bytes for the MAC header parser.
module eth_preamble_sync
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE_BITS = 16,
    parameter int MAX_FRAME_BYTES   = 1518
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_carrier,
    input  logic       i_bit_valid,
    input  logic       i_bit,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_err
);

    localparam int ALT_W = $clog2(MIN_PREAMBLE_BITS + 1);
    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [ALT_W-1:0] ALT_MAX = ALT_W'(MIN_PREAMBLE_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BYTES);

    function automatic logic [ALT_W-1:0] alt_inc(input logic [ALT_W-1:0] v);
        return (v >= ALT_MAX) ? ALT_MAX : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    sync_state_e      state_q, state_d;
    logic [ALT_W-1:0] alt_q, alt_d;
    logic             prev_q, prev_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld_q, byte_vld_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            alt_q      <= '0;
            prev_q     <= 1'b0;
            bit_idx_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alt_q      <= alt_d;
            prev_q     <= prev_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alt_d      = alt_q;
        prev_d     = prev_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_carrier && i_bit_valid && i_bit) begin
                    state_d    = PREAMBLE;
                    alt_d      = ALT_W'(1);
                    prev_d     = 1'b1;
                    bit_idx_d  = '0;
                    byte_cnt_d = '0;
                end
            end

            PREAMBLE: begin
                // Carrier loss here is an aborted preamble, not a broken frame.
                if (!i_carrier) begin
                    state_d    = IDLE;
                    alt_d      = '0;
                    bit_idx_d  = '0;
                    byte_cnt_d = '0;
                end else if (i_bit_valid) begin
                    prev_d = i_bit;
                    if (i_bit != prev_q) begin
                        alt_d = alt_inc(alt_q);
                    end else if (i_bit && (alt_q >= ALT_MAX)) begin
                        state_d    = DATA;
                        alt_d      = '0;
                        bit_idx_d  = '0;
                        byte_cnt_d = '0;
                    end else begin
                        state_d = DROP;
                        err_d   = 1'b1;
                    end
                end
            end

            DATA: begin
                if (!i_carrier) begin
                    state_d    = IDLE;
                    eof_d      = 1'b1;
                    err_d      = (bit_idx_q != 3'd0);
                    alt_d      = '0;
                    bit_idx_d  = '0;
                    byte_cnt_d = '0;
                end else if (i_bit_valid) begin
                    shift_d[bit_idx_q] = i_bit;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        // A byte beyond the frame limit is never forwarded.
                        if (byte_cnt_q == CNT_MAX) begin
                            state_d = DROP;
                            eof_d   = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            byte_d     = shift_d;
                            byte_vld_d = 1'b1;
                            sof_d      = (byte_cnt_q == '0);
                            byte_cnt_d = cnt_inc(byte_cnt_q);
                        end
                    end
                end
            end

            DROP: begin
                if (!i_carrier) begin
                    state_d    = IDLE;
                    alt_d      = '0;
                    bit_idx_d  = '0;
                    byte_cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_vld_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_eth_preamble_sync.sv
// Scoreboard bench for eth_preamble_sync: each scenario queues the output events
// it expects, and a negedge monitor pops and compares them as the DUT emits them.
module tb_eth_preamble_sync;
    import eth_pkg::*;

    localparam int MAXB = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_carrier = 1'b0;
    logic       i_bit_valid = 1'b0;
    logic       i_bit = 1'b0;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       o_sof;
    logic       o_eof;
    logic       o_err;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  hold_exp = 8'h00;
    logic [11:0] mon_act;
    logic [11:0] mon_exp;

    eth_preamble_sync #(
        .MIN_PREAMBLE_BITS(16),
        .MAX_FRAME_BYTES  (MAXB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_carrier   (i_carrier),
        .i_bit_valid (i_bit_valid),
        .i_bit       (i_bit),
        .o_byte      (o_byte),
        .o_byte_valid(o_byte_valid),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Event word: {byte_valid, sof, eof, err, byte (zero when no strobe)}.
    always @(negedge i_clk) begin
        mon_act = {o_byte_valid, o_sof, o_eof, o_err, (o_byte_valid ? o_byte : 8'h00)};
        if (o_byte_valid || o_sof || o_eof || o_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {20'h0, mon_act}, 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event", {20'h0, mon_act}, {20'h0, mon_exp});
                if (mon_exp[11]) hold_exp = mon_exp[7:0];
            end
        end
        if (!o_byte_valid) chk("byte_hold", {24'h0, o_byte}, {24'h0, hold_exp});
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic sof);
        exp_q.push_back({1'b1, sof, 2'b00, b});
    endtask

    task automatic push_pulse(input logic eof, input logic err);
        exp_q.push_back({2'b00, eof, err, 8'h00});
    endtask

    task automatic send_bit(input logic b);
        i_bit       = b;
        i_bit_valid = 1'b1;
        step();
        i_bit_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lat);
        for (int i = 0; i < 8; i++) begin
            i_bit       = b[i];
            i_bit_valid = 1'b1;
            step();
            i_bit_valid = 1'b0;
            if (i == 7 && lat) chk("strobe_latency", {31'h0, o_byte_valid}, 32'h1);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic preamble(input int n);
        i_carrier = 1'b1;
        repeat (n) send_byte(PREAMBLE_BYTE, 1'b0);
        send_byte(SFD_BYTE, 1'b0);
    endtask

    task automatic carrier_off();
        i_carrier   = 1'b0;
        i_bit_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 32'h0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_byte"}, {24'h0, o_byte}, 32'h0);
        chk({tag, "_flags"}, {28'h0, o_byte_valid, o_sof, o_eof, o_err}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1;
        repeat (2) step();
        chk_outputs_zero("reset");
        i_rst = 1'b0;
        step();

        // Good frame; leading zeros in IDLE are ignored.
        i_carrier = 1'b1;
        repeat (3) send_bit(1'b0);
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b0);
        push_pulse(1'b1, 1'b0);
        preamble(7);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        carrier_off();
        drain();

        // Short preamble: 15 alternating bits before the SFD end.
        push_pulse(1'b0, 1'b1);
        preamble(1);
        send_byte(8'h01, 1'b0);
        carrier_off();
        drain();

        // Two consecutive zeros in the preamble; remaining bits ignored.
        push_pulse(1'b0, 1'b1);
        i_carrier = 1'b1;
        send_byte(8'h55, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(SFD_BYTE, 1'b0);
        send_byte(8'hAB, 1'b0);
        carrier_off();
        drain();

        // Partial trailing byte: eof and err together.
        push_byte(8'hAA, 1'b1);
        push_pulse(1'b1, 1'b1);
        preamble(7);
        send_byte(8'hAA, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        carrier_off();
        drain();

        // Oversized frame with a 4-byte limit.
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b0);
        push_byte(8'h12, 1'b0);
        push_byte(8'h13, 1'b0);
        push_pulse(1'b1, 1'b1);
        preamble(7);
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1'b1);
        send_byte(8'h14, 1'b0);
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        carrier_off();
        drain();

        // 17 alternating bits: just above the minimum, frame accepted.
        push_byte(8'h3C, 1'b1);
        push_pulse(1'b1, 1'b0);
        i_carrier = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        preamble(1);
        send_byte(8'h3C, 1'b1);
        carrier_off();
        drain();

        // Carrier drop coinciding with the 8th bit: the bit is discarded.
        push_byte(8'h77, 1'b1);
        push_pulse(1'b1, 1'b1);
        preamble(7);
        send_byte(8'h77, 1'b1);
        repeat (7) send_bit(1'b1);
        i_carrier   = 1'b0;
        i_bit       = 1'b1;
        i_bit_valid = 1'b1;
        step();
        i_bit_valid = 1'b0;
        carrier_off();
        drain();

        // Aborted preamble is silent; the next frame is received normally.
        i_carrier = 1'b1;
        repeat (3) send_byte(PREAMBLE_BYTE, 1'b0);
        carrier_off();
        push_byte(8'h9A, 1'b1);
        push_pulse(1'b1, 1'b0);
        preamble(7);
        send_byte(8'h9A, 1'b1);
        carrier_off();
        drain();

        // Reset mid-frame after the second byte, with a bit offered in the same cycle.
        push_byte(8'hA1, 1'b1);
        push_byte(8'hA2, 1'b0);
        preamble(7);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        repeat (3) step();
        drain();
        chk("pre_reset_byte", {24'h0, o_byte}, 32'hA2);
        i_rst       = 1'b1;
        i_bit       = 1'b1;
        i_bit_valid = 1'b1;
        step();
        hold_exp    = 8'h00;
        i_bit_valid = 1'b0;
        chk_outputs_zero("midframe_reset");
        i_rst = 1'b0;
        carrier_off();
        push_byte(8'hB1, 1'b1);
        push_byte(8'hB2, 1'b0);
        push_pulse(1'b1, 1'b0);
        preamble(7);
        send_byte(8'hB1, 1'b1);
        send_byte(8'hB2, 1'b1);
        carrier_off();
        drain();

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
